// File: rtl/ins_loader.sv
// rtl/ins_loader.sv - UART 8N1 receiver that packs bytes into 32-bit instruction-memory writes
module ins_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RXD,
  input  logic              START,
  output logic              WE,
  output logic [31:0]       W_Ins,
  output logic [ADDR_W-1:0] W_Addr,
  output logic              BUSY,
  output logic              ERR
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        rx_meta;
  logic        rxs;
  logic [TW-1:0] tmr;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [23:0] asm_word;
  logic [1:0]  byte_cnt;
  logic        we_r;

  logic        tmr_clr;
  logic        shift_en;
  logic        byte_ok;
  logic        frame_err;

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RXD;
      rxs     <= rx_meta;
    end
  end

  // Receiver state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Receiver next-state and per-cycle sampling strobes; START overrides all
  always_comb begin
    state_nx  = state;
    tmr_clr   = 1'b0;
    shift_en  = 1'b0;
    byte_ok   = 1'b0;
    frame_err = 1'b0;
    case (state)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (!rxs) begin
          state_nx = ST_START;
        end
      end
      ST_START: begin
        if (tmr == HALF_BIT) begin
          tmr_clr  = 1'b1;
          state_nx = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tmr == LAST_TICK) begin
          tmr_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            state_nx = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tmr == LAST_TICK) begin
          tmr_clr  = 1'b1;
          state_nx = ST_IDLE;
          if (rxs) begin
            byte_ok = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        tmr_clr  = 1'b1;
      end
    endcase
    if (START) begin
      state_nx  = ST_IDLE;
      tmr_clr   = 1'b1;
      shift_en  = 1'b0;
      byte_ok   = 1'b0;
      frame_err = 1'b0;
    end
  end

  // Bit timer, bit shifter, word assembly and write-port registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmr      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      asm_word <= '0;
      byte_cnt <= '0;
      we_r     <= 1'b0;
      W_Ins    <= '0;
      W_Addr   <= '0;
      ERR      <= 1'b0;
    end else begin
      tmr <= tmr_clr ? '0 : tmr + 1'b1;

      if (state == ST_IDLE) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 1'b1;
      end

      // LSB arrives first, so shift in from the top
      if (shift_en) begin
        shreg <= {rxs, shreg[7:1]};
      end

      we_r <= 1'b0;
      // Address advances the cycle after the write it labelled
      if (we_r) begin
        W_Addr <= W_Addr + 1'b1;
      end

      if (byte_ok) begin
        if (byte_cnt == 2'd3) begin
          W_Ins    <= {asm_word, shreg};
          we_r     <= 1'b1;
          byte_cnt <= '0;
        end else begin
          asm_word <= {asm_word[15:0], shreg};
          byte_cnt <= byte_cnt + 1'b1;
        end
      end

      // A bad stop bit poisons the whole partial word
      if (frame_err) begin
        ERR      <= 1'b1;
        byte_cnt <= '0;
      end

      if (START) begin
        W_Addr   <= '0;
        byte_cnt <= '0;
        ERR      <= 1'b0;
        we_r     <= 1'b0;
      end
    end
  end

  assign WE   = we_r & ~START;
  assign BUSY = (state != ST_IDLE);

endmodule
